adc_multi_model: RTL and testbench
==================================

# adc_multi_model

Parametrised behavioural model of an SPI 12-bit multi-channel A2D converter, the successor to the fixed three-channel Segway A2D model. It is used in Segway testbenches behind the A2D interface master. It holds one value register per channel with a programmable step-down ramp, saturating or wrapping. It adds a testbench load port, invalid-channel detection and abort handling.

## Interface
- NUM_CH, 8: number of valid channels, 1..8. The channel field is always cmd[13:11].
- RES, 12: conversion width, 1..16.
- INIT, 12'hC00: reset value of every channel, RES bits.
- STEP, 12'h010: amount subtracted per step, RES bits.
- READS_PER_STEP, 2: number of reads of a channel between steps, ≥1.
- WRAP, 0: 0 = saturate at 0; 1 = modulo 2^RES.
- TAG_CH, 1: 1 = OR the channel number into the low 3 bits of the response.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active low.
- SS_n  in  1  slave select, active low.
- SCLK  in  1  serial clock, idles high.
- MOSI  in  1  serial data from the master.
- MISO  out  1  serial data to the master; high-Z while SS_n is high.
- ld  in  1  testbench load strobe.
- ld_ch  in  3  channel to load.
- ld_val  in  RES  value to load.
- rdy  out  1  one-clock pulse on completion of each full frame.
- bad_ch  out  1  sticky flag: an addressed channel was ≥ NUM_CH.
- last_cmd  out  16  last complete command word received.

## Operation
- **Input synchronisation:** SS_n, SCLK and MOSI each pass through 2-flop synchronisers, then edge detection.
- **Frame FSM states:** IDLE, SHIFT, WAIT_SS.
  - IDLE → SHIFT on SS_n fall. At that point: tx_shft is loaded with the response for ptr, served_ch <= ptr, bit_cnt <= 0.
  - SHIFT, on each SCLK rise: MOSI shifts into rx_shft (MSB first), bit_cnt++.
  - SHIFT, on each SCLK fall: tx_shft shifts left.
  - SHIFT, on the 16th rise: frame completes, go to WAIT_SS.
  - SHIFT, on SS_n rise with bit_cnt<16: abort, go to IDLE. No rdy, no pointer/value/counter update.
  - WAIT_SS → IDLE on SS_n rise.
- **Response word:** {(16-RES)'0, value[served_ch]} | (TAG_CH ? served_ch : 0). If served_ch ≥ NUM_CH, the response is 16'h0000.
- **Pipelining:** the data returned in frame N is for the channel addressed in frame N-1. The first frame after reset returns channel 0.
- **On completion, all in one clock:**
  - rdy=1.
  - last_cmd <= rx word.
  - ptr <= rx[13:11].
  - If rx[13:11] ≥ NUM_CH: bad_ch <= 1.
  - If served_ch < NUM_CH: rcnt[served_ch]++. When it reaches READS_PER_STEP: rcnt <= 0 and value[served_ch] steps.
- **Step arithmetic:** value - STEP.
  - WRAP=0: clamp at 0 when value < STEP.
  - WRAP=1: RES-bit wrap.
- **Load port:** ld sets value[ld_ch] <= ld_val and clears rcnt[ld_ch]. ld_ch ≥ NUM_CH is ignored.
- **Load/step collision:** ld on the same clock as a step of the same channel: ld wins. ld on a different channel: both apply.
- **Mid-frame load:** a load does not alter the word already in tx_shft.

## Timing
- **Reset values:** state=IDLE, ptr=0, value[*]=INIT, rcnt[*]=0, rdy=0, bad_ch=0, last_cmd=0, MISO=Z.
- **Reset mid-frame:** the frame is dropped and the next SS_n fall starts clean.
- **Input latency:** an edge at a pin is acted on 3 clk later (2 synchroniser flops + edge register).
- **rdy latency:** rdy asserts 1 clk after the 16th SCLK rise is detected. ptr, value, rcnt and last_cmd are updated on the same edge.
- **MISO bit 15:** valid 3 clk after SS_n fall. Each subsequent bit is valid 3 clk after an SCLK fall.
- **Master constraints:** SCLK high and low phases ≥ 4 clk; SS_n fall to first SCLK fall ≥ 4 clk.
- **SCLK while idle:** SCLK edges with SS_n high, or in WAIT_SS, are ignored.

## Structure
- **Shared package adc_model_pkg:** frame_state_t enum (IDLE, SHIFT, WAIT_SS), FRAME_BITS=16, CH_MSB=13, CH_LSB=11.
- **Sub-module adc_spi_slave:** synchronisers, frame FSM, shift registers, bit counter. Outputs: rx word, rdy pulse, frame_start pulse. Input: tx word.
- **Top level:** the value array, rcnt array, ptr, served_ch and step/load logic.

## Test plan
All scenarios use default parameters unless stated.

- **Ramp:** frames cmd 16'h2000 ×4 → responses 0xC00, 0xC04, 0xC04, 0xBF4.
- **Saturate vs wrap:** TAG_CH=0, READS_PER_STEP=1, ld ch5=0x005, 5 frames addressing ch5.
  - WRAP=0: reads 0xC00, then 0x005, 0x000, 0x000.
  - WRAP=1: reads 0xC00, then 0x005, 0xFF5.
- **Invalid channel:** NUM_CH=6, cmd ch7 (16'h3800) → next frame returns 0x0000, bad_ch=1. bad_ch stays 1 until rst_n; value[*] unchanged.
- **Abort:** SS_n rises after 8 SCLKs → no rdy; ptr and rcnt unchanged. The next full frame returns the same word as the aborted one would have.
- **Load/step collision:** ld ch4=0x800 on the same clk as ch4's step → value[4]=0x800 and rcnt[4]=0. The next read returns 0x804.
- **Reset mid-frame:** assert rst_n low at bit 9 → MISO=Z, bad_ch=0. The next frame returns 0xC00.

Source files
------------

// File: rtl/adc_model_pkg.sv
// Shared types and frame geometry for the multi-channel SPI A2D behavioural model.
package adc_model_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_SS} frame_state_t;
  localparam int FRAME_BITS = 16;
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;
endpackage

// File: rtl/adc_multi_model_if.sv
// Master-driven SPI pins of the A2D model (MISO is a tristate pin on the top level).
interface adc_multi_model_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;

  modport master (output SS_n, output SCLK, output MOSI);
  modport slave  (input SS_n, input SCLK, input MOSI);
endinterface

// File: rtl/adc_spi_slave.sv
// SPI frame engine: pin synchronisers, edge detect, frame FSM and shift registers.
module adc_spi_slave
  import adc_model_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  adc_multi_model_if.slave      spi,
  input  logic [FRAME_BITS-1:0] tx_word_i,
  output logic [FRAME_BITS-1:0] rx_word_o,
  output logic                  frame_start_o,
  output logic                  frame_done_o,
  output logic                  miso_bit_o,
  output logic                  miso_en_o
);
  frame_state_t          state_q, state_d;
  logic [2:0]            ss_q, sclk_q;
  logic [1:0]            mosi_q;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d, tx_q, tx_d;
  logic                  ss_fall, ss_rise, sclk_rise, sclk_fall;

  // SS_n sync resets low so a select still held across reset never looks like a new fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q      <= '0;
      sclk_q    <= '1;
      mosi_q    <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
    end else begin
      ss_q      <= {ss_q[1:0], spi.SS_n};
      sclk_q    <= {sclk_q[1:0], spi.SCLK};
      mosi_q    <= {mosi_q[0], spi.MOSI};
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
    end
  end

  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    frame_start_o = 1'b0;
    frame_done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d       = SHIFT;
          tx_d          = tx_word_i;
          bit_cnt_d     = '0;
          frame_start_o = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_d      = {rx_q[FRAME_BITS-2:0], mosi_q[1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
              frame_done_o = 1'b1;
              state_d      = WAIT_SS;
            end
          end
          // the leading fall precedes the first sample, so bit 15 must survive it
          if (sclk_fall && bit_cnt_q != 5'd0)
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      WAIT_SS: begin
        if (ss_rise)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_word_o  = rx_d;
  assign miso_bit_o = tx_q[FRAME_BITS-1];
  assign miso_en_o  = (state_q != IDLE);
endmodule

// File: rtl/adc_multi_model.sv
// Multi-channel SPI A2D model: per-channel ramping value registers behind a pipelined read.
module adc_multi_model
  import adc_model_pkg::*;
#(
  parameter int             NUM_CH         = 8,
  parameter int             RES            = 12,
  parameter logic [RES-1:0] INIT           = 12'hC00,
  parameter logic [RES-1:0] STEP           = 12'h010,
  parameter int             READS_PER_STEP = 2,
  parameter int             WRAP           = 0,
  parameter int             TAG_CH         = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adc_multi_model_if.slave      spi,
  output wire                   MISO,
  input  logic                  ld,
  input  logic [2:0]            ld_ch,
  input  logic [RES-1:0]        ld_val,
  output logic                  rdy,
  output logic                  bad_ch,
  output logic [FRAME_BITS-1:0] last_cmd
);
  localparam int CW = (READS_PER_STEP > 1) ? $clog2(READS_PER_STEP) : 1;

  logic [FRAME_BITS-1:0] tx_word, rx_word, last_cmd_q;
  logic                  frame_start, frame_done, miso_bit, miso_en;
  logic [2:0]            ptr_q, served_q, rx_ch;
  logic                  rdy_q, bad_q;
  logic [RES-1:0]        value_w [NUM_CH];

  adc_spi_slave u_spi (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (spi),
    .tx_word_i     (tx_word),
    .rx_word_o     (rx_word),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .miso_bit_o    (miso_bit),
    .miso_en_o     (miso_en)
  );

  assign MISO  = (miso_en && !spi.SS_n) ? miso_bit : 1'bz;
  assign rx_ch = rx_word[CH_MSB:CH_LSB];

  function automatic logic [RES-1:0] step_value(input logic [RES-1:0] v);
    if (WRAP == 0 && v < STEP)
      return '0;
    return v - STEP;
  endfunction

  // Response for the channel latched by the previous frame; unknown channels read as zero
  always_comb begin
    tx_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ptr_q == 3'(i))
        tx_word = 16'(value_w[i]) | ((TAG_CH != 0) ? 16'(ptr_q) : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      served_q   <= '0;
      rdy_q      <= 1'b0;
      bad_q      <= 1'b0;
      last_cmd_q <= '0;
    end else begin
      rdy_q <= frame_done;
      if (frame_start)
        served_q <= ptr_q;
      if (frame_done) begin
        last_cmd_q <= rx_word;
        ptr_q      <= rx_ch;
        if (int'(rx_ch) >= NUM_CH)
          bad_q <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [RES-1:0] val_q;
    logic [CW-1:0]  rcnt_q;
    logic           load, hit, step;

    assign load = ld && (ld_ch == 3'(gi));
    assign hit  = frame_done && (served_q == 3'(gi));
    assign step = hit && (rcnt_q == CW'(READS_PER_STEP - 1));

    // a load on the step clock overrides the step
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_q  <= INIT;
        rcnt_q <= '0;
      end else if (load) begin
        val_q  <= ld_val;
        rcnt_q <= '0;
      end else if (step) begin
        val_q  <= step_value(val_q);
        rcnt_q <= '0;
      end else if (hit) begin
        rcnt_q <= rcnt_q + CW'(1);
      end
    end

    assign value_w[gi] = val_q;
  end

  assign rdy      = rdy_q;
  assign bad_ch   = bad_q;
  assign last_cmd = last_cmd_q;
endmodule

// File: tb/tb_adc_multi_model.sv
// Bench for adc_multi_model: three parameterisations share one SPI master and load port.
module tb_adc_multi_model;
  logic        clk;
  logic        rst_n;
  logic        ld;
  logic [2:0]  ld_ch;
  logic [11:0] ld_val;
  wire         miso0, miso1, miso2;
  logic        miso_v [3];
  logic        rdy_v  [3];
  logic        bad_v  [3];
  logic [15:0] last_v [3];
  int          tests, fails, rdy_cnt0;

  typedef struct {
    int          sel;
    logic        rst;
    logic        pre_ld;
    logic [2:0]  lch;
    logic [11:0] lval;
    logic [15:0] cmd;
    logic [15:0] resp;
    logic        bad;
  } vec_t;
  typedef struct {
    logic [15:0] resp;
    logic [15:0] cmd;
  } exp_t;

  vec_t vecs [16];
  exp_t sb_q [$];

  adc_multi_model_if spi_if ();

  pullup   (miso1);
  pulldown (miso2);
  assign miso_v[0] = miso0;
  assign miso_v[1] = miso1;
  assign miso_v[2] = miso2;

  adc_multi_model dut0 (
    .clk(clk), .rst_n(rst_n), .spi(spi_if), .MISO(miso0), .ld(ld), .ld_ch(ld_ch),
    .ld_val(ld_val), .rdy(rdy_v[0]), .bad_ch(bad_v[0]), .last_cmd(last_v[0]));
  adc_multi_model #(.NUM_CH(6), .READS_PER_STEP(1), .WRAP(0), .TAG_CH(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi(spi_if), .MISO(miso1), .ld(ld), .ld_ch(ld_ch),
    .ld_val(ld_val), .rdy(rdy_v[1]), .bad_ch(bad_v[1]), .last_cmd(last_v[1]));
  adc_multi_model #(.READS_PER_STEP(1), .WRAP(1), .TAG_CH(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .spi(spi_if), .MISO(miso2), .ld(ld), .ld_ch(ld_ch),
    .ld_val(ld_val), .rdy(rdy_v[2]), .bad_ch(bad_v[2]), .last_cmd(last_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rdy_v[0]) rdy_cnt0 <= rdy_cnt0 + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; ld = 1'b0;
    spi_if.SS_n = 1'b1; spi_if.SCLK = 1'b1; spi_if.MOSI = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic pulse_ld(input logic [2:0] ch, input logic [11:0] val);
    @(negedge clk);
    ld = 1'b1; ld_ch = ch; ld_val = val;
    wait_clk(1);
    ld = 1'b0;
  endtask

  // Select, then n SCLK periods; returns with SCLK just raised for the n-th time
  task automatic shift_bits(input int sel, input logic [15:0] cmd, input int n,
                            output logic [15:0] got);
    got = '0;
    @(negedge clk);
    spi_if.SS_n = 1'b0;
    wait_clk(5);
    for (int i = 15; i > 15 - n; i--) begin
      spi_if.SCLK = 1'b0;
      spi_if.MOSI = cmd[i];
      wait_clk(5);
      got[i] = miso_v[sel];
      spi_if.SCLK = 1'b1;
      if (i > 16 - n) wait_clk(5);
    end
  endtask

  task automatic do_frame(input int sel, input logic [15:0] cmd, input logic [15:0] resp,
                          input logic ld_done, input logic [2:0] lch, input logic [11:0] lval);
    logic [15:0] got;
    exp_t        e;
    sb_q.push_back('{resp, cmd});
    shift_bits(sel, cmd, 16, got);
    wait_clk(2);
    check("rdy_early", 32'(rdy_v[sel]), 32'd0);
    if (ld_done) begin
      ld = 1'b1; ld_ch = lch; ld_val = lval;
    end
    wait_clk(1);
    ld = 1'b0;
    check("rdy_pulse", 32'(rdy_v[sel]), 32'd1);
    e = sb_q.pop_front();
    check("resp", 32'(got), 32'(e.resp));
    check("last_cmd", 32'(last_v[sel]), 32'(e.cmd));
    $display("[TB] dut%0d cmd=%h resp=%h exp=%h bad_ch=%0b", sel, cmd, got, e.resp, bad_v[sel]);
    wait_clk(4);
    spi_if.SS_n = 1'b1;
    wait_clk(6);
  endtask

  initial begin
    logic [15:0] part;
    int          rc;
    tests = 0; fails = 0; rdy_cnt0 = 0;
    rst_n = 1'b0; ld = 1'b0; ld_ch = '0; ld_val = '0;
    spi_if.SS_n = 1'b1; spi_if.SCLK = 1'b1; spi_if.MOSI = 1'b0;

    //            sel rst   preld lch   lval     cmd       resp      bad
    vecs[0]  = '{0, 1'b1, 1'b0, 3'd0, 12'h000, 16'h2000, 16'h0C00, 1'b0};
    vecs[1]  = '{0, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2000, 16'h0C04, 1'b0};
    vecs[2]  = '{0, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2000, 16'h0C04, 1'b0};
    vecs[3]  = '{0, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2000, 16'h0BF4, 1'b0};
    vecs[4]  = '{1, 1'b1, 1'b1, 3'd5, 12'h005, 16'h2800, 16'h0C00, 1'b0};
    vecs[5]  = '{1, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2800, 16'h0005, 1'b0};
    vecs[6]  = '{1, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2800, 16'h0000, 1'b0};
    vecs[7]  = '{1, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2800, 16'h0000, 1'b0};
    vecs[8]  = '{1, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2800, 16'h0000, 1'b0};
    vecs[9]  = '{2, 1'b1, 1'b1, 3'd5, 12'h005, 16'h2800, 16'h0C00, 1'b0};
    vecs[10] = '{2, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2800, 16'h0005, 1'b0};
    vecs[11] = '{2, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2800, 16'h0FF5, 1'b0};
    vecs[12] = '{2, 1'b0, 1'b0, 3'd0, 12'h000, 16'h2800, 16'h0FE5, 1'b0};
    vecs[13] = '{1, 1'b1, 1'b0, 3'd0, 12'h000, 16'h3800, 16'h0C00, 1'b1};
    vecs[14] = '{1, 1'b0, 1'b0, 3'd0, 12'h000, 16'h0000, 16'h0000, 1'b1};
    vecs[15] = '{1, 1'b0, 1'b0, 3'd0, 12'h000, 16'h0000, 16'h0BF0, 1'b1};

    apply_reset();
    for (int d = 0; d < 3; d++) begin
      check("reset_rdy", 32'(rdy_v[d]), 32'd0);
      check("reset_bad", 32'(bad_v[d]), 32'd0);
      check("reset_last_cmd", 32'(last_v[d]), 32'd0);
    end
    check("reset_miso_z_pullup", 32'(miso_v[1]), 32'd1);
    check("reset_miso_z_pulldown", 32'(miso_v[2]), 32'd0);

    for (int v = 0; v < 16; v++) begin
      if (vecs[v].rst) apply_reset();
      if (vecs[v].pre_ld) pulse_ld(vecs[v].lch, vecs[v].lval);
      do_frame(vecs[v].sel, vecs[v].cmd, vecs[v].resp, 1'b0, 3'd0, 12'h000);
      check("bad_ch", 32'(bad_v[vecs[v].sel]), 32'(vecs[v].bad));
    end

    // Abort after 8 SCLKs (MOSI carries ch1): no rdy, ptr and rcnt of ch4 untouched
    apply_reset();
    do_frame(0, 16'h2000, 16'h0C00, 1'b0, 3'd0, 12'h000);
    rc = rdy_cnt0;
    shift_bits(0, 16'h0800, 8, part);
    wait_clk(5);
    spi_if.SS_n = 1'b1;
    wait_clk(8);
    check("abort_partial_byte", 32'(part[15:8]), 32'h0C);
    check("abort_no_rdy", 32'(rdy_cnt0), 32'(rc));
    $display("[TB] dut0 aborted frame, partial=%h", part[15:8]);
    do_frame(0, 16'h2000, 16'h0C04, 1'b0, 3'd0, 12'h000);
    do_frame(0, 16'h2000, 16'h0C04, 1'b0, 3'd0, 12'h000);
    do_frame(0, 16'h2000, 16'h0BF4, 1'b0, 3'd0, 12'h000);

    // Load on the step clock of the same channel, then on a different channel
    apply_reset();
    do_frame(0, 16'h2000, 16'h0C00, 1'b0, 3'd0, 12'h000);
    do_frame(0, 16'h2000, 16'h0C04, 1'b0, 3'd0, 12'h000);
    do_frame(0, 16'h2000, 16'h0C04, 1'b1, 3'd4, 12'h800);
    do_frame(0, 16'h2000, 16'h0804, 1'b0, 3'd0, 12'h000);
    do_frame(0, 16'h2000, 16'h0804, 1'b1, 3'd3, 12'h123);
    do_frame(0, 16'h1800, 16'h07F4, 1'b0, 3'd0, 12'h000);
    do_frame(0, 16'h0000, 16'h0123, 1'b0, 3'd0, 12'h000);

    // Reset at bit 9 of a frame serving an invalid channel
    apply_reset();
    do_frame(1, 16'h3800, 16'h0C00, 1'b0, 3'd0, 12'h000);
    check("midrst_bad_before", 32'(bad_v[1]), 32'd1);
    shift_bits(1, 16'h0000, 9, part);
    wait_clk(5);
    check("midrst_miso_driven", 32'(miso_v[1]), 32'd0);
    rst_n = 1'b0;
    wait_clk(1);
    check("midrst_miso_z", 32'(miso_v[1]), 32'd1);
    check("midrst_bad", 32'(bad_v[1]), 32'd0);
    check("midrst_rdy", 32'(rdy_v[1]), 32'd0);
    spi_if.SS_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    $display("[TB] dut1 reset mid-frame at bit 9");
    do_frame(1, 16'h0000, 16'h0C00, 1'b0, 3'd0, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
